// File: rtl/mbus_tx_arbiter.sv
// rtl/mbus_tx_arbiter.sv - round-robin arbiter sharing the MBus master TX port
//
// Hands the single layer-wrapper TX port to one of NUM_REQ requesters for a
// whole message: every TX_PEND-chained word plus the SUCC/FAIL response
// handshake. Requesters are granted round-robin starting at rr_ptr.
//
// Optional feature macro: MBUS_TXARB_PRIO_EN
//   defined   : requesters raising REQ_TX_PRIORITY with REQ_TX_REQ win the
//               grant over plain requesters; round-robin within each class.
//   undefined : pure round-robin; REQ_TX_PRIORITY is only passed through.
//
// Ports:
//   CLK_EXT, RESETn            clock, asynchronous active-low reset
//   REQ_TX_ADDR/DATA           packed per-requester address/data, slice i = requester i
//   REQ_TX_REQ/PEND/PRIORITY   per-requester word request, more-words, MBus priority
//   REQ_TX_RESP_ACK            per-requester acknowledge of SUCC/FAIL
//   REQ_TX_ACK/SUCC/FAIL       controller responses, routed to the owner only
//   TX_ADDR/DATA/REQ/PEND/PRIORITY/RESP_ACK   to the MBus controller
//   TX_ACK/SUCC/FAIL           from the MBus controller
//   GRANT_VALID, GRANT_ID      current owner of the port

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbus_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                           CLK_EXT,
  input  logic                           RESETn,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0] REQ_TX_ADDR,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0] REQ_TX_DATA,
  input  logic [NUM_REQ-1:0]             REQ_TX_REQ,
  input  logic [NUM_REQ-1:0]             REQ_TX_PEND,
  input  logic [NUM_REQ-1:0]             REQ_TX_PRIORITY,
  input  logic [NUM_REQ-1:0]             REQ_TX_RESP_ACK,
  output logic [NUM_REQ-1:0]             REQ_TX_ACK,
  output logic [NUM_REQ-1:0]             REQ_TX_SUCC,
  output logic [NUM_REQ-1:0]             REQ_TX_FAIL,
  output logic [`ADDR_WIDTH-1:0]         TX_ADDR,
  output logic [`DATA_WIDTH-1:0]         TX_DATA,
  output logic                           TX_REQ,
  output logic                           TX_PEND,
  output logic                           TX_PRIORITY,
  output logic                           TX_RESP_ACK,
  input  logic                           TX_ACK,
  input  logic                           TX_SUCC,
  input  logic                           TX_FAIL,
  output logic                           GRANT_VALID,
  output logic [IDX_W-1:0]               GRANT_ID
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  if (IDX_W != $clog2(NUM_REQ)) begin : g_idx_w_check
    $error("IDX_W must equal clog2(NUM_REQ)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant_id;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_id;
  logic [IDX_W-1:0]   next_ptr;
  logic               grant_valid;
  logic               last_word;
  logic               ack_d;
  logic               resp_done;
  logic [NUM_REQ-1:0] cand;

  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               sel_req;
  logic               sel_pend;
  logic               sel_prio;
  logic               sel_rack;

  // Requesters eligible for the next grant.
  always_comb begin
    cand = REQ_TX_REQ;
`ifdef MBUS_TXARB_PRIO_EN
    if ((REQ_TX_REQ & REQ_TX_PRIORITY) != '0) begin
      cand = REQ_TX_REQ & REQ_TX_PRIORITY;
    end
`endif
  end

  // Nearest candidate at or above rr_ptr (with wrap) wins: smallest
  // circular distance from the pointer.
  always_comb begin
    int best_d;
    int d;
    pick_id = rr_ptr;
    best_d  = NUM_REQ;
    d       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
      if (cand[i] && (d < best_d)) begin
        best_d  = d;
        pick_id = IDX_W'(i);
      end
    end
  end

  assign next_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

  // Owner's request slice, selected by the registered grant index.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_req  = 1'b0;
    sel_pend = 1'b0;
    sel_prio = 1'b0;
    sel_rack = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        sel_addr = REQ_TX_ADDR[i*AW +: AW];
        sel_data = REQ_TX_DATA[i*DW +: DW];
        sel_req  = REQ_TX_REQ[i];
        sel_pend = REQ_TX_PEND[i];
        sel_prio = REQ_TX_PRIORITY[i];
        sel_rack = REQ_TX_RESP_ACK[i];
      end
    end
  end

  // Everything is gated by state so an asynchronous reset clears the
  // controller-facing port in the same cycle.
  assign TX_ADDR     = grant_valid ? sel_addr : '0;
  assign TX_DATA     = grant_valid ? sel_data : '0;
  assign TX_PEND     = grant_valid ? sel_pend : 1'b0;
  assign TX_PRIORITY = grant_valid ? sel_prio : 1'b0;
  assign TX_REQ      = (state == ST_XFER) ? sel_req  : 1'b0;
  assign TX_RESP_ACK = (state == ST_RESP) ? sel_rack : 1'b0;

  always_comb begin
    REQ_TX_ACK  = '0;
    REQ_TX_SUCC = '0;
    REQ_TX_FAIL = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        REQ_TX_ACK[i]  = (state == ST_XFER) && TX_ACK;
        REQ_TX_SUCC[i] = (state == ST_RESP) && TX_SUCC;
        REQ_TX_FAIL[i] = (state == ST_RESP) && TX_FAIL;
      end
    end
  end

  assign GRANT_VALID = grant_valid;
  assign GRANT_ID    = grant_id;

  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      rr_ptr      <= '0;
      last_word   <= 1'b0;
      ack_d       <= 1'b0;
      resp_done   <= 1'b0;
    end else begin
      ack_d <= TX_ACK;
      case (state)
        ST_IDLE: begin
          if (REQ_TX_REQ != '0) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            last_word   <= 1'b0;
            resp_done   <= 1'b0;
            state       <= ST_XFER;
          end
        end
        ST_XFER: begin
          // PEND is captured as the ack rises; the requester may already
          // be presenting its next word by the time the ack falls.
          if (TX_ACK && !ack_d) begin
            last_word <= ~sel_pend;
          end
          // A response during the transfer is a controller abort.
          if (TX_SUCC || TX_FAIL) begin
            state <= ST_RESP;
          end else if (!TX_ACK && ack_d && last_word) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if ((TX_SUCC || TX_FAIL) && sel_rack) begin
            resp_done <= 1'b1;
          end
          if (resp_done && !TX_SUCC && !TX_FAIL && !sel_rack) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
          end
        end
        default: begin
          state       <= ST_IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// tb/tb_mbus_tx_arbiter.sv - self-checking bench for mbus_tx_arbiter

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mbus_tx_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_req = '0;
  logic [N-1:0]    req_pend = '0;
  logic [N-1:0]    req_prio = '0;
  logic [N-1:0]    req_resp_ack = '0;
  logic            tx_ack = 1'b0;
  logic            tx_succ = 1'b0;
  logic            tx_fail = 1'b0;

  logic [N-1:0]    REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL;
  logic [AW-1:0]   TX_ADDR;
  logic [DW-1:0]   TX_DATA;
  logic            TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK;
  logic            GRANT_VALID;
  logic [IW-1:0]   GRANT_ID;

  mbus_tx_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .CLK_EXT         (clk),
    .RESETn          (rst_n),
    .REQ_TX_ADDR     (req_addr),
    .REQ_TX_DATA     (req_data),
    .REQ_TX_REQ      (req_req),
    .REQ_TX_PEND     (req_pend),
    .REQ_TX_PRIORITY (req_prio),
    .REQ_TX_RESP_ACK (req_resp_ack),
    .REQ_TX_ACK      (REQ_TX_ACK),
    .REQ_TX_SUCC     (REQ_TX_SUCC),
    .REQ_TX_FAIL     (REQ_TX_FAIL),
    .TX_ADDR         (TX_ADDR),
    .TX_DATA         (TX_DATA),
    .TX_REQ          (TX_REQ),
    .TX_PEND         (TX_PEND),
    .TX_PRIORITY     (TX_PRIORITY),
    .TX_RESP_ACK     (TX_RESP_ACK),
    .TX_ACK          (tx_ack),
    .TX_SUCC         (tx_succ),
    .TX_FAIL         (tx_fail),
    .GRANT_VALID     (GRANT_VALID),
    .GRANT_ID        (GRANT_ID)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=none expected=event", name);
  endtask

  // ---------------- reference model ----------------
  // m_stage: 0 no owner, 1 owner sending words, 2 owner in response handshake
  int m_stage = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  bit m_final = 1'b0;
  bit m_ack_prev = 1'b0;
  bit m_done = 1'b0;

  function automatic int pick();
    int best = 0;
    int bestd = N + 1;
    bit prio_class = 1'b0;
`ifdef MBUS_TXARB_PRIO_EN
    for (int i = 0; i < N; i++) if (req_req[i] && req_prio[i]) prio_class = 1'b1;
`endif
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i - m_ptr + N) % N;
      if (req_req[i] && (!prio_class || req_prio[i]) && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= 0; m_owner <= 0; m_ptr <= 0;
      m_final <= 1'b0; m_ack_prev <= 1'b0; m_done <= 1'b0;
    end else begin
      m_ack_prev <= tx_ack;
      if (m_stage == 0) begin
        if (req_req != '0) begin
          m_owner <= pick(); m_stage <= 1; m_final <= 1'b0; m_done <= 1'b0;
        end
      end else if (m_stage == 1) begin
        if (tx_ack && !m_ack_prev) m_final <= !req_pend[m_owner];
        if (tx_succ || tx_fail) m_stage <= 2;
        else if (!tx_ack && m_ack_prev && m_final) m_stage <= 2;
      end else begin
        if ((tx_succ || tx_fail) && req_resp_ack[m_owner]) m_done <= 1'b1;
        if (m_done && !tx_succ && !tx_fail && !req_resp_ack[m_owner]) begin
          m_stage <= 0;
          m_ptr   <= (m_owner + 1) % N;
        end
      end
    end
  end

  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_req, e_pend, e_prio, e_rack, e_valid;
  logic [N-1:0]  e_ack, e_succ, e_fail;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_addr = '0; e_data = '0; e_req = 1'b0; e_pend = 1'b0; e_prio = 1'b0;
      e_rack = 1'b0; e_valid = 1'b0; e_ack = '0; e_succ = '0; e_fail = '0;
      if (m_stage != 0) begin
        e_valid = 1'b1;
        e_addr  = req_addr[m_owner*AW +: AW];
        e_data  = req_data[m_owner*DW +: DW];
        e_pend  = req_pend[m_owner];
        e_prio  = req_prio[m_owner];
        if (m_stage == 1) begin
          e_req = req_req[m_owner];
          e_ack[m_owner] = tx_ack;
        end else begin
          e_succ[m_owner] = tx_succ;
          e_fail[m_owner] = tx_fail;
          e_rack = req_resp_ack[m_owner];
        end
      end
      check("tx_bus", 128'({TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK}),
            128'({e_addr, e_data, e_req, e_pend, e_prio, e_rack}));
      check("req_side", 128'({REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL}), 128'({e_ack, e_succ, e_fail}));
      check("grant", 128'({GRANT_VALID, GRANT_ID}), 128'({e_valid, IW'(m_owner)}));
    end
  end

  // ---------------- requester / controller stimulus ----------------
  int words_left[N];
  int word_no[N];

  int           glog;      // grant order, one decimal digit per message (id+1)
  int           plog;      // TX_PRIORITY at grant, one digit per message
  logic [N-1:0] ack_seen, succ_seen, fail_seen;
  logic [AW-1:0] alog[4];
  int           alog_n;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    glog = 0; plog = 0; ack_seen = '0; succ_seen = '0; fail_seen = '0; alog_n = 0;
  endtask

  task automatic set_word(input int i);
    req_addr[i*AW +: AW] = AW'(32'hA000_0000 + i*16 + word_no[i]);
    req_data[i*DW +: DW] = DW'(32'hD000_0000 + i*256 + word_no[i]);
    req_pend[i] = (words_left[i] > 1);
    req_req[i]  = 1'b1;
  endtask

  task automatic start_msg(input int i, input int nw, input logic prio);
    words_left[i] = nw;
    word_no[i]    = 0;
    req_prio[i]   = prio;
    set_word(i);
  endtask

  task automatic drop_req(input int i);
    words_left[i] = 0;
    req_req[i] = 1'b0; req_pend[i] = 1'b0; req_prio[i] = 1'b0;
  endtask

  task automatic advance(input int i);
    words_left[i]--;
    word_no[i]++;
    if (words_left[i] > 0) set_word(i);
    else drop_req(i);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) drop_req(i);
    req_resp_ack = '0; tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
  endtask

  task automatic wait_stage(input int s, output bit ok);
    int t = 0;
    while (m_stage != s && t < 20) begin cyc(1); t++; end
    ok = (m_stage == s);
  endtask

  // Serves one complete message for whoever the model says owns the port.
  // fail_after >= 0 aborts with TX_FAIL after that many acked words.
  task automatic serve(input int fail_after);
    int own;
    int w;
    int t;
    bit ok;
    bit last;
    wait_stage(1, ok);
    if (!ok) begin timeout("grant_wait"); return; end
    own  = m_owner;
    glog = glog * 10 + int'(GRANT_ID) + 1;
    plog = plog * 10 + int'(TX_PRIORITY);
    w = 0;
    last = 1'b0;
    while (!last && w != fail_after) begin
      t = 0;
      while (TX_REQ !== 1'b1 && t < 20) begin cyc(1); t++; end
      if (TX_REQ !== 1'b1) begin timeout("tx_req_wait"); return; end
      tx_ack = 1'b1;
      cyc(1);
      ack_seen |= REQ_TX_ACK;
      if (alog_n < 4) begin alog[alog_n] = TX_ADDR; alog_n++; end
      last = (req_pend[own] == 1'b0);
      advance(own);
      cyc(1);
      tx_ack = 1'b0;
      cyc(2);
      w++;
    end
    if (fail_after >= 0) tx_fail = 1'b1;
    else begin
      wait_stage(2, ok);
      if (!ok) begin timeout("resp_wait"); return; end
      tx_succ = 1'b1;
    end
    cyc(1);
    succ_seen |= REQ_TX_SUCC;
    fail_seen |= REQ_TX_FAIL;
    req_resp_ack[own] = 1'b1;
    if (fail_after >= 0) drop_req(own);
    cyc(1);
    tx_succ = 1'b0; tx_fail = 1'b0;
    cyc(1);
    req_resp_ack[own] = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    clear_logs();
    for (int i = 0; i < N; i++) begin words_left[i] = 0; word_no[i] = 0; end
    cyc(1);
    cmp_en = 1'b1;
    do_reset();
    check("reset_state", 128'({GRANT_VALID, GRANT_ID, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
                               TX_ADDR, TX_DATA, REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL}), 128'(0));

    // Single 3-word message from requester 1.
    clear_logs();
    start_msg(1, 3, 1'b0);
    serve(-1);
    check("single_grant", 128'(glog), 128'(2));
    check("single_addr0", 128'(alog[0]), 128'(32'hA000_0010));
    check("single_addr2", 128'(alog[2]), 128'(32'hA000_0012));
    check("single_ack_bits", 128'(ack_seen), 128'(4'b0010));
    check("single_succ_bits", 128'(succ_seen), 128'(4'b0010));

    // Mid-message fail with rr_ptr=2: req2 (4 words) and req3 waiting.
    clear_logs();
    start_msg(2, 4, 1'b0);
    start_msg(3, 2, 1'b0);
    serve(1);
    serve(-1);
    check("fail_order", 128'(glog), 128'(34));
    check("fail_bits", 128'(fail_seen), 128'(4'b0100));
    check("fail_succ_bits", 128'(succ_seen), 128'(4'b1000));

    // Contention with rr_ptr=0: req0, req2, req3 together.
    clear_logs();
    start_msg(0, 2, 1'b0);
    start_msg(2, 1, 1'b0);
    start_msg(3, 2, 1'b0);
    serve(-1); serve(-1); serve(-1);
    check("contention_order", 128'(glog), 128'(134));
    check("contention_ack_bits", 128'(ack_seen), 128'(4'b1101));

    // Move rr_ptr to 3, then wrap-around: req3 and req0.
    clear_logs();
    start_msg(2, 1, 1'b0);
    serve(-1);
    check("ptr_to_3", 128'(glog), 128'(3));
    clear_logs();
    start_msg(0, 1, 1'b0);
    start_msg(3, 1, 1'b0);
    serve(-1); serve(-1);
    check("wrap_order", 128'(glog), 128'(41));
    clear_logs();
    start_msg(0, 1, 1'b0);
    start_msg(1, 1, 1'b0);
    serve(-1); serve(-1);
    check("ptr_after_wrap", 128'(glog), 128'(21));

    // Async reset mid-word while requester 1 holds the port.
    start_msg(1, 3, 1'b0);
    begin
      bit ok;
      wait_stage(1, ok);
      if (!ok) timeout("rst_grant_wait");
    end
    tx_ack = 1'b1;
    cyc(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 128'({TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
                                  REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL, GRANT_VALID}), 128'(0));
    clear_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 128'({GRANT_VALID, GRANT_ID}), 128'(0));
    cyc(1);
    clear_logs();
    start_msg(1, 1, 1'b0);
    start_msg(0, 1, 1'b0);
    serve(-1); serve(-1);
    check("post_rst_order", 128'(glog), 128'(12));

    // Priority class: req0 plain, req2 priority, rr_ptr=0.
    do_reset();
    clear_logs();
    start_msg(0, 1, 1'b0);
    start_msg(2, 1, 1'b1);
    serve(-1); serve(-1);
`ifdef MBUS_TXARB_PRIO_EN
    check("prio_order", 128'(glog), 128'(31));
    check("prio_tx_priority", 128'(plog), 128'(10));
`else
    check("prio_order", 128'(glog), 128'(13));
    check("prio_tx_priority", 128'(plog), 128'(1));
`endif

    cyc(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
